// File: rtl/multiplier_seq_n_bits_pkg.sv
// Shared arithmetic definitions for the sequential shift-add multiplier.
package multiplier_seq_n_bits_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Width of the iteration counter that runs 0 .. n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/register_N_bits_ena_aclr.sv
// N-bit register with load enable and asynchronous active-high clear.
module register_N_bits_ena_aclr #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         aclr_i,
    input  logic         ena_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;

    always_ff @(posedge clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            q_q <= '0;
        end else if (ena_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/multiplier_seq_n_bits.sv
// Sequential N x N shift-add multiplier, unsigned or two's-complement, one
// iteration per clock with a one-cycle done pulse when the product updates.
module multiplier_seq_n_bits
    import multiplier_seq_n_bits_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk_i,
    input  logic           aclr_i,
    input  logic [N-1:0]   data_i,
    input  logic           ea_i,
    input  logic           eb_i,
    input  logic           start_i,
    input  logic           sgn_i,
    output logic [2*N-1:0] p_o,
    output logic           busy_o,
    output logic           done_o
);

    localparam int unsigned     CntW    = cnt_width(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    logic [N-1:0]   a_q, b_q;
    state_e         state_q;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]   a_w_q, b_w_q;
    logic           sgn_w_q;
    logic [2*N-1:0] acc_q, acc_d;
    logic           busy_q, done_q;
    logic [2*N-1:0] a_ext, pp, term;
    logic           last, accept;

    register_N_bits_ena_aclr #(.N(N)) u_reg_a (
        .clk_i  (clk_i),
        .aclr_i (aclr_i),
        .ena_i  (ea_i),
        .d_i    (data_i),
        .q_o    (a_q)
    );

    register_N_bits_ena_aclr #(.N(N)) u_reg_b (
        .clk_i  (clk_i),
        .aclr_i (aclr_i),
        .ena_i  (eb_i),
        .d_i    (data_i),
        .q_o    (b_q)
    );

    register_N_bits_ena_aclr #(.N(2 * N)) u_reg_p (
        .clk_i  (clk_i),
        .aclr_i (aclr_i),
        .ena_i  (last),
        .d_i    (acc_d),
        .q_o    (p_o)
    );

    always_comb begin
        last   = (state_q == StRun) && (cnt_q == LastCnt);
        // The completing edge already leaves RUN, so a new start is taken there.
        accept = start_i && ((state_q == StIdle) || last);
        a_ext  = {{N{a_w_q[N-1] & sgn_w_q}}, a_w_q};
        pp     = a_ext << cnt_q;
        term   = b_w_q[cnt_q] ? pp : '0;
        // In signed mode the B MSB carries negative weight.
        if (sgn_w_q && (cnt_q == LastCnt)) begin
            acc_d = acc_q - term;
        end else begin
            acc_d = acc_q + term;
        end
    end

    always_ff @(posedge clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_w_q   <= '0;
            b_w_q   <= '0;
            sgn_w_q <= 1'b0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                state_q <= StRun;
                cnt_q   <= '0;
                a_w_q   <= a_q;
                b_w_q   <= b_q;
                sgn_w_q <= sgn_i;
                acc_q   <= '0;
                busy_q  <= 1'b1;
            end else if (state_q == StRun) begin
                acc_q <= acc_d;
                if (last) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_multiplier_seq_n_bits.sv
// Directed self-checking bench for multiplier_seq_n_bits at N = 8.
module tb_multiplier_seq_n_bits;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic [7:0]  data = '0;
    logic        ea = 1'b0;
    logic        eb = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [15:0] p;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    multiplier_seq_n_bits #(.N(8)) dut (
        .clk_i   (clk),
        .aclr_i  (aclr),
        .data_i  (data),
        .ea_i    (ea),
        .eb_i    (eb),
        .start_i (start),
        .sgn_i   (sgn),
        .p_o     (p),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        data = a;
        ea   = 1'b1;
        step();
        ea   = 1'b0;
        data = b;
        eb   = 1'b1;
        step();
        eb   = 1'b0;
    endtask

    // Issue one multiply and check timing of busy/done plus the product.
    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] exp);
        int busy_n;
        int done_n;
        busy_n = 0;
        done_n = 0;
        load(a, b);
        sgn   = s;
        start = 1'b1;
        step();
        start = 1'b0;
        sgn   = 1'b0;
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c < 8) begin
                busy_n += int'(busy);
                done_n += int'(done);
            end else begin
                check({tag, " done at k+8"}, 32'(done), 32'd1);
                check({tag, " busy at k+8"}, 32'(busy), 32'd0);
                check({tag, " product"}, 32'(p), 32'(exp));
            end
        end
        check({tag, " busy cycles"}, 32'(busy_n + 1), 32'd8);
        check({tag, " early done"}, 32'(done_n), 32'd0);
        step();
        check({tag, " done pulse width"}, 32'(done), 32'd0);
        check({tag, " product held"}, 32'(p), 32'(exp));
    endtask

    initial begin
        int extra_done;

        #2;
        check("reset P", 32'(p), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        step();
        aclr = 1'b0;
        step();

        // Cleared A and B give a zero product.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) step();
        check("reset operands product", 32'(p), 32'd0);
        step();

        run_mul("u 13x11", 8'd13, 8'd11, 1'b0, 16'h008F);
        run_mul("s -3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        run_mul("s 80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_mul("u FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_mul("s FFxFF", 8'hFF, 8'hFF, 1'b1, 16'h0001);

        // Operand reload during RUN, dropped starts, back-to-back completion.
        load(8'd13, 8'd11);
        start = 1'b1;
        step();
        start = 1'b0;
        extra_done = 0;
        for (int c = 1; c <= 16; c++) begin
            data  = 8'd0;
            ea    = 1'b0;
            eb    = 1'b0;
            start = 1'b0;
            if (c == 3) begin
                data = 8'd2;
                ea   = 1'b1;
            end
            if (c == 4) begin
                data = 8'd3;
                eb   = 1'b1;
            end
            if (c == 5 || c == 8 || c == 9 || c == 12) start = 1'b1;
            step();
            if (c == 8) begin
                check("b2b first done", 32'(done), 32'd1);
                check("b2b first product", 32'(p), 32'h008F);
            end else if (c == 16) begin
                check("b2b second done", 32'(done), 32'd1);
                check("b2b second product", 32'(p), 32'd6);
            end else begin
                extra_done += int'(done);
                if (c == 12) check("b2b product held mid-run", 32'(p), 32'h008F);
            end
        end
        start = 1'b0;
        check("b2b extra done", 32'(extra_done), 32'd0);
        step();
        check("b2b idle after", 32'(busy), 32'd0);

        // Asynchronous clear in the middle of a multiply.
        load(8'h55, 8'h33);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        check("clr busy before", 32'(busy), 32'd1);
        #2;
        aclr = 1'b1;
        #1;
        check("clr P async", 32'(p), 32'd0);
        check("clr busy async", 32'(busy), 32'd0);
        check("clr done async", 32'(done), 32'd0);
        step();
        aclr = 1'b0;
        extra_done = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            extra_done += int'(done);
        end
        check("clr no done after", 32'(extra_done), 32'd0);
        check("clr P stays 0", 32'(p), 32'd0);
        run_mul("u 7x9 after clr", 8'd7, 8'd9, 1'b0, 16'd63);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
